// File: rtl/twos_to_signmag_serial_pkg.sv
// Shared definitions for the bit-serial two's-complement to sign-magnitude decoder.
// Holds the FSM state encoding and the step-counter width helper.
package twos_to_signmag_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Step counter must index 0..WIDTH-1.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared across the team's serial arithmetic blocks.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Y,
   output logic Cout
);

   assign Y    = A ^ B ^ Cin;
   assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder: one word per WIDTH+2 cycles,
// magnitude rebuilt LSB-first through one full adder and a carry flop.
//
// state | meaning
// IDLE  | in_ready high, waiting for an input word
// SHIFT | WIDTH serial steps building |value| into res
// DONE  | out_valid high, holding out_sm/out_ovf until out_ready
module twos_to_signmag_serial
   import twos_to_signmag_serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sm,
   output logic             out_ovf
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [CNT_W-1:0] count;
   logic             sign;
   logic             carry;
   logic             fa_a;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;

   // Negative words are inverted and incremented serially; positive words pass straight through.
   assign fa_a   = sign ? ~sr[0] : sr[0];
   assign fa_cin = sign & carry;

   full_adder u_fa (
      .A    (fa_a),
      .B    (1'b0),
      .Cin  (fa_cin),
      .Y    (fa_sum),
      .Cout (fa_cout)
   );

   assign res_next = {fa_sum, res[WIDTH-1:1]};
   assign in_ready = (state == ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         sr        <= '0;
         res       <= '0;
         count     <= '0;
         sign      <= 1'b0;
         carry     <= 1'b0;
         out_valid <= 1'b0;
         out_sm    <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sr    <= in_data;
                  sign  <= in_data[WIDTH-1];
                  carry <= 1'b1;
                  count <= '0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sr    <= sr >> 1;
               res   <= res_next;
               carry <= fa_cout;
               count <= count + CNT_W'(1);
               if (count == LAST_STEP) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  // Only the most-negative input yields a magnitude with the top bit set.
                  if (sign && res_next[WIDTH-1]) begin
                     out_ovf <= 1'b1;
                     out_sm  <= '1;
                  end else begin
                     out_ovf <= 1'b0;
                     out_sm  <= {sign, res_next[WIDTH-2:0]};
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for twos_to_signmag_serial with WIDTH=8 and hand-computed results.
module tb_twos_to_signmag_serial;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sm;
   logic       out_ovf;

   int checks = 0;
   int errors = 0;

   twos_to_signmag_serial #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sm    (out_sm),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for in_ready, then presents one word for exactly one accept edge.
   task automatic accept_word(input logic [7:0] d);
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   // Returns edges from accept until out_valid, or -1 on timeout.
   task automatic wait_valid(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (out_valid === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      step();
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sm !== 8'h00 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b sm=%h ovf=%b required 1 0 00 0",
                  in_ready, out_valid, out_sm, out_ovf);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_positive();
      int cyc;
      accept_word(8'h05);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_ready: in_ready=%b required 0", in_ready);
      end
      wait_valid(cyc);
      checks++;
      if (cyc != 8) begin
         errors++;
         $display("FAIL latency_05: cycles=%0d required 8", cyc);
      end
      checks++;
      if (out_sm !== 8'h05 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL value_05: sm=%h ovf=%b required 05 0", out_sm, out_ovf);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL return_idle: vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_negative();
      logic [7:0] din [2]  = '{8'hFB, 8'hFF};
      logic [7:0] exp_sm [2] = '{8'h85, 8'h81};
      int cyc;
      for (int k = 0; k < 2; k++) begin
         accept_word(din[k]);
         wait_valid(cyc);
         checks++;
         if (cyc != 8 || out_sm !== exp_sm[k] || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL negative_%h: cycles=%0d sm=%h ovf=%b required 8 %h 0",
                     din[k], cyc, out_sm, out_ovf, exp_sm[k]);
         end
         step();
      end
   endtask

   task automatic test_boundary();
      logic [7:0] din [3]     = '{8'h80, 8'h7F, 8'h00};
      logic [7:0] exp_sm [3]  = '{8'hFF, 8'h7F, 8'h00};
      logic       exp_ovf [3] = '{1'b1, 1'b0, 1'b0};
      int cyc;
      for (int k = 0; k < 3; k++) begin
         accept_word(din[k]);
         wait_valid(cyc);
         checks++;
         if (cyc != 8 || out_sm !== exp_sm[k] || out_ovf !== exp_ovf[k]) begin
            errors++;
            $display("FAIL boundary_%h: cycles=%0d sm=%h ovf=%b required 8 %h %b",
                     din[k], cyc, out_sm, out_ovf, exp_sm[k], exp_ovf[k]);
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      out_ready = 1'b0;
      accept_word(8'hFE);
      wait_valid(cyc);
      checks++;
      if (cyc != 8 || out_sm !== 8'h82 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp_value: cycles=%0d sm=%h ovf=%b required 8 82 0", cyc, out_sm, out_ovf);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h11;
         step();
         checks++;
         if (out_valid !== 1'b1 || out_sm !== 8'h82 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: vld=%b sm=%h ovf=%b rdy=%b required 1 82 0 0",
                     i, out_valid, out_sm, out_ovf, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_single_transfer_%0d: vld=%b required 0", i, out_valid);
         end
      end
   endtask

   task automatic test_data_change();
      int cyc = -1;
      accept_word(8'hC4);
      for (int i = 1; i <= 20; i++) begin
         in_data = 8'($urandom);
         step();
         if (out_valid === 1'b1) begin
            cyc = i;
            break;
         end
      end
      // 0xC4 = -60 -> magnitude 0x3C
      checks++;
      if (cyc != 8 || out_sm !== 8'hBC || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL data_change: cycles=%0d sm=%h ovf=%b required 8 bc 0", cyc, out_sm, out_ovf);
      end
      step();
   endtask

   task automatic test_async_reset();
      int cyc;
      accept_word(8'h9A);
      for (int i = 0; i < 3; i++) step();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_sm !== 8'h00 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: vld=%b sm=%h ovf=%b rdy=%b required 0 00 0 1",
                  out_valid, out_sm, out_ovf, in_ready);
      end
      step();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL discard_%0d: vld=%b required 0", i, out_valid);
         end
      end
      accept_word(8'hF0);
      wait_valid(cyc);
      checks++;
      if (cyc != 8 || out_sm !== 8'h90 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_f0: cycles=%0d sm=%h ovf=%b required 8 90 0", cyc, out_sm, out_ovf);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int cyc;
      accept_word(8'h01);
      wait_valid(cyc);
      step();
      // Handshake taken; the very next edge must accept a new word.
      in_valid = 1'b1;
      in_data  = 8'hE0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      wait_valid(cyc);
      checks++;
      if (cyc != 8 || out_sm !== 8'hA0 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL b2b_value: cycles=%0d sm=%h ovf=%b required 8 a0 0", cyc, out_sm, out_ovf);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_positive();
      test_negative();
      test_boundary();
      test_backpressure();
      test_data_change();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
